// File: rtl/fpu_ss_pkg.sv
// fpu_ss_pkg: shared types for the FPU subsystem writeback path.
//   FPU_SS_FLEN : data width carried by wb_entry_t (arbiter FLEN must match).
//   wb_entry_t  : one queued FPnew result (data, rd, rd_is_fp, id, fflags).
//   wb_src_e    : source selected for the FP register-file write port.
package fpu_ss_pkg;

   localparam int unsigned FPU_SS_FLEN = 32;

   typedef struct packed {
      logic [FPU_SS_FLEN-1:0] data;
      logic [4:0]             rd;
      logic                   rd_is_fp;
      logic [3:0]             id;
      logic [4:0]             fflags;
   } wb_entry_t;

   typedef enum logic [1:0] {
      WB_SRC_NONE,
      WB_SRC_MEM,
      WB_SRC_HEAD,
      WB_SRC_BYPASS
   } wb_src_e;

endpackage

// File: rtl/fpu_ss_wb_fifo.sv
// fpu_ss_wb_fifo: DEPTH-entry FIFO of wb_entry_t (DEPTH a power of two, >= 2).
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset (flushes contents)
//   push_i/data_i  write request and entry (ignored when full)
//   pop_i          remove head (ignored when empty)
//   data_o         current head entry
//   full_o/empty_o occupancy flags
//   count_o        occupancy, $clog2(DEPTH)+1 bits
module fpu_ss_wb_fifo
   import fpu_ss_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  wb_entry_t              data_i,
   input  logic                   pop_i,
   output wb_entry_t              data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   count_q;
   wb_entry_t     mem_q [DEPTH];
   logic          push_en, pop_en;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rptr_q];
   assign push_en = push_i & ~full_o;
   assign pop_en  = pop_i & ~empty_o;

   // Pointers are AW bits wide, so increment wraps modulo DEPTH.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_en) wptr_q <= wptr_q + 1'b1;
         if (pop_en)  rptr_q <= rptr_q + 1'b1;
         if (push_en && !pop_en)      count_q <= count_q + 1'b1;
         else if (pop_en && !push_en) count_q <= count_q - 1'b1;
      end
   end

   // Storage needs no reset: it is only observed through a non-empty head.
   always_ff @(posedge clk_i) begin
      if (push_en) mem_q[wptr_q] <= data_i;
   end

endmodule

// File: rtl/fpu_ss_wb_arbiter.sv
// fpu_ss_wb_arbiter: shares the FP register-file write port between FPnew
// results and load responses, and routes integer-destination FPnew results
// to the core result channel. Loads always win the FPR port; a starvation
// counter raises mem_hold_o when an FP head is blocked STARVE_LIMIT cycles.
// Optional feature macro: FPU_SS_WB_BYPASS_EN (empty-FIFO same-cycle bypass).
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   fpu_out_*                     FPnew result stream (valid/ready)
//   mem_rsp_*                     load responses (never stalled)
//   fpr_we_o/waddr_o/wdata_o      FP register-file write port
//   result_*                      integer result channel (valid/ready)
//   release_*                     one-cycle pulse per retired FPnew result
//   mem_hold_o                    stop issuing memory requests
//   busy_o                        skid FIFO not empty
module fpu_ss_wb_arbiter
   import fpu_ss_pkg::*;
#(
   parameter int unsigned FLEN         = FPU_SS_FLEN,
   parameter int unsigned XLEN         = 32,
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            fpu_out_valid_i,
   output logic            fpu_out_ready_o,
   input  logic [FLEN-1:0] fpu_out_data_i,
   input  logic [4:0]      fpu_out_rd_i,
   input  logic            fpu_out_rd_is_fp_i,
   input  logic [3:0]      fpu_out_id_i,
   input  logic [4:0]      fpu_out_fflags_i,
   input  logic            mem_rsp_valid_i,
   input  logic [FLEN-1:0] mem_rsp_data_i,
   input  logic [4:0]      mem_rsp_rd_i,
   output logic            fpr_we_o,
   output logic [4:0]      fpr_waddr_o,
   output logic [FLEN-1:0] fpr_wdata_o,
   output logic            result_valid_o,
   input  logic            result_ready_i,
   output logic [XLEN-1:0] result_data_o,
   output logic [4:0]      result_rd_o,
   output logic [3:0]      result_id_o,
   output logic [4:0]      result_fflags_o,
   output logic            release_valid_o,
   output logic [4:0]      release_rd_o,
   output logic            release_is_fp_o,
   output logic [3:0]      release_id_o,
   output logic            mem_hold_o,
   output logic            busy_o
);

   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   wb_entry_t             in_entry, head;
   logic                  full, empty;
   logic [$clog2(DEPTH):0] count;
   logic                  push, head_pop, head_fp, head_int, bypass;
   wb_src_e               fpr_src;
   logic [SW-1:0]         starve_q, starve_d;

   assign in_entry = '{data: fpu_out_data_i, rd: fpu_out_rd_i, rd_is_fp: fpu_out_rd_is_fp_i,
                       id: fpu_out_id_i, fflags: fpu_out_fflags_i};

   assign head_fp  = ~empty & head.rd_is_fp;
   assign head_int = ~empty & ~head.rd_is_fp;
   assign head_pop = (head_fp & ~mem_rsp_valid_i) | (head_int & result_ready_i);

`ifdef FPU_SS_WB_BYPASS_EN
   assign bypass = empty & fpu_out_valid_i &
                   (fpu_out_rd_is_fp_i ? ~mem_rsp_valid_i : result_ready_i);
`else
   assign bypass = 1'b0;
`endif

   // Ready is purely ~full; a same-cycle pop does not open a slot.
   assign fpu_out_ready_o = ~full;
   assign push            = fpu_out_valid_i & ~full & ~bypass;
   assign busy_o          = ~empty;
   assign mem_hold_o      = (starve_q == SW'(STARVE_LIMIT));

   fpu_ss_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .data_i  (in_entry),
      .pop_i   (head_pop),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );

   always_comb begin
      fpr_src = WB_SRC_NONE;
      if (mem_rsp_valid_i)                fpr_src = WB_SRC_MEM;
      else if (head_fp)                   fpr_src = WB_SRC_HEAD;
      else if (bypass && in_entry.rd_is_fp) fpr_src = WB_SRC_BYPASS;
   end

   always_comb begin
      fpr_we_o    = 1'b0;
      fpr_waddr_o = '0;
      fpr_wdata_o = '0;
      unique case (fpr_src)
         WB_SRC_MEM: begin
            fpr_we_o    = 1'b1;
            fpr_waddr_o = mem_rsp_rd_i;
            fpr_wdata_o = mem_rsp_data_i;
         end
         WB_SRC_HEAD: begin
            fpr_we_o    = 1'b1;
            fpr_waddr_o = head.rd;
            fpr_wdata_o = head.data;
         end
         WB_SRC_BYPASS: begin
            fpr_we_o    = 1'b1;
            fpr_waddr_o = in_entry.rd;
            fpr_wdata_o = in_entry.data;
         end
         default: ;
      endcase
   end

   always_comb begin
      result_valid_o  = 1'b0;
      result_data_o   = '0;
      result_rd_o     = '0;
      result_id_o     = '0;
      result_fflags_o = '0;
      if (head_int) begin
         result_valid_o  = 1'b1;
         result_data_o   = head.data[XLEN-1:0];
         result_rd_o     = head.rd;
         result_id_o     = head.id;
         result_fflags_o = head.fflags;
      end else if (bypass && !in_entry.rd_is_fp) begin
         result_valid_o  = 1'b1;
         result_data_o   = in_entry.data[XLEN-1:0];
         result_rd_o     = in_entry.rd;
         result_id_o     = in_entry.id;
         result_fflags_o = in_entry.fflags;
      end
   end

   always_comb begin
      release_valid_o = 1'b0;
      release_rd_o    = '0;
      release_is_fp_o = 1'b0;
      release_id_o    = '0;
      if (head_pop) begin
         release_valid_o = 1'b1;
         release_rd_o    = head.rd;
         release_is_fp_o = head.rd_is_fp;
         release_id_o    = head.id;
      end else if (bypass) begin
         release_valid_o = 1'b1;
         release_rd_o    = in_entry.rd;
         release_is_fp_o = in_entry.rd_is_fp;
         release_id_o    = in_entry.id;
      end
   end

   always_comb begin
      starve_d = starve_q;
      if (head_pop)
         starve_d = '0;
      else if (head_fp && mem_rsp_valid_i && !mem_hold_o)
         starve_d = starve_q + 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) starve_q <= '0;
      else       starve_q <= starve_d;
   end

   logic unused_count;
   assign unused_count = ^count;

endmodule
